// File: rtl/clk_logic_alu.sv
// Registered two-stage logic/arithmetic unit with valid/ready handshaking and an internal accumulator.
// Optional saturating arithmetic is enabled by defining CLK_ALU_SAT_EN.
module clk_logic_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_NAND   = 3'd3;
    localparam logic [2:0] OP_ADD    = 3'd4;
    localparam logic [2:0] OP_SUB    = 3'd5;
    localparam logic [2:0] OP_LOAD   = 3'd6;
    localparam logic [2:0] OP_ACCADD = 3'd7;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] acc;
    logic             s2_adv;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic [WIDTH:0]   sum_ab;
    logic [WIDTH:0]   diff_ab;
    logic [WIDTH:0]   sum_acc;

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_adv;

    // When in_ready is high stage 1 is either empty or emptying, so it simply takes whatever is offered.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    assign sum_ab  = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff_ab = {1'b0, s1_a} - {1'b0, s1_b};
    assign sum_acc = {1'b0, acc} + {1'b0, s1_a};

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        case (s1_op)
            OP_AND:  res = s1_a & s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_NAND: res = ~(s1_a & s1_b);
            OP_ADD: begin
                res_c = sum_ab[WIDTH];
`ifdef CLK_ALU_SAT_EN
                res   = res_c ? '1 : sum_ab[WIDTH-1:0];
`else
                res   = sum_ab[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                res_c = diff_ab[WIDTH];
`ifdef CLK_ALU_SAT_EN
                res   = res_c ? '0 : diff_ab[WIDTH-1:0];
`else
                res   = diff_ab[WIDTH-1:0];
`endif
            end
            OP_LOAD: res = s1_a;
            OP_ACCADD: begin
                res_c = sum_acc[WIDTH];
`ifdef CLK_ALU_SAT_EN
                res   = res_c ? '1 : sum_acc[WIDTH-1:0];
`else
                res   = sum_acc[WIDTH-1:0];
`endif
            end
        endcase
    end

    // The accumulator moves only with the stage-2 advance, so a stalled beat cannot apply twice.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (s2_adv && (s1_op == OP_LOAD || s1_op == OP_ACCADD)) begin
            acc <= res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            y         <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            y         <= res;
            carry     <= res_c;
            zero      <= (res == '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
        end
    end

endmodule
